// File: rtl/serial_adder_ctrl_if.sv
// Host-side handshake and operand/result bundle for the bit-serial adder controller.
// The host drives the master modport; the controller sits on the slave modport.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout;

  modport master (
    output start,
    output a_in,
    output b_in,
    output cin,
    input  busy,
    input  done,
    input  sum_out,
    input  cout
  );

  modport slave (
    input  start,
    input  a_in,
    input  b_in,
    input  cin,
    output busy,
    output done,
    output sum_out,
    output cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full-adder slice (two half adders plus a carry OR)
// walks the operands LSB first, one bit per clock, and reports the result with a done pulse.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             p, g1, s, g2, carry_nxt;
  logic [WIDTH-1:0] res_shift;

  // Shared full-adder slice built from two half-adder stages.
  always_comb begin
    p         = a_q[0] ^ b_q[0];
    g1        = a_q[0] & b_q[0];
    s         = p ^ carry_q;
    g2        = p & carry_q;
    carry_nxt = g1 | g2;
    res_shift = res_q >> 1;
    res_shift[WIDTH-1] = s;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          carry_d = bus.cin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_shift;
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // Publish on the last bit so sum_out/cout are already valid while done is high.
          sum_d   = res_shift;
          cout_d  = carry_nxt;
          state_d = DONE;
        end
      end
      DONE: begin
        sum_d   = res_q;
        cout_d  = carry_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.sum_out = sum_q;
  assign bus.cout    = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed scenarios plus random operands checked
// against plain integer addition, on an 8-bit and a 1-bit instance.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;
  localparam int P = W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_adder_ctrl_if #(.WIDTH(W)) m8 ();
  serial_adder_ctrl_if #(.WIDTH(1)) m1 ();

  serial_adder_ctrl #(.WIDTH(W)) u8 (.clk(clk), .rst(rst), .bus(m8));
  serial_adder_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(m1));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one start and watches W+6 cycles; lat counts edges from the accept edge to done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output logic [W-1:0] s, output logic co, output logic [W-1:0] s_end,
                       output int lat, output int nbusy, output int ndone);
    m8.start = 1'b1;
    m8.a_in  = a;
    m8.b_in  = b;
    m8.cin   = c;
    step();
    m8.start = 1'b0;
    m8.a_in  = W'($urandom);
    m8.b_in  = W'($urandom);
    m8.cin   = 1'($urandom);
    lat = -1; nbusy = 0; ndone = 0; s = 'x; co = 1'bx;
    for (int k = 0; k < P + 4; k++) begin
      if (m8.busy === 1'b1) nbusy++;
      if (m8.done === 1'b1) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          s   = m8.sum_out;
          co  = m8.cout;
        end
      end
      step();
    end
    s_end = m8.sum_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m8.start = 1'b0; m8.a_in = '0; m8.b_in = '0; m8.cin = 1'b0;
    m1.start = 1'b0; m1.a_in = '0; m1.b_in = '0; m1.cin = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({m8.busy, m8.done, m8.cout, m8.sum_out} !== '0) begin
        errors++;
        $display("FAIL reset_idle8 cycle %0d: busy=%b done=%b cout=%b sum=%h, want all 0",
                 i, m8.busy, m8.done, m8.cout, m8.sum_out);
      end
      checks++;
      if ({m1.busy, m1.done, m1.cout, m1.sum_out} !== '0) begin
        errors++;
        $display("FAIL reset_idle1 cycle %0d: busy=%b done=%b cout=%b sum=%h, want all 0",
                 i, m1.busy, m1.done, m1.cout, m1.sum_out);
      end
      m8.a_in = W'($urandom);
      step();
    end
  endtask

  // done appears W edges after the accept edge: WIDTH+2 cycles counting the start cycle.
  task automatic test_basic();
    logic [W-1:0] s, s_end;
    logic co;
    int lat, nbusy, ndone;
    do_op(8'hFF, 8'h01, 1'b0, s, co, s_end, lat, nbusy, ndone);
    checks++;
    if (lat + 2 !== P) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, want %0d", lat + 2, P);
    end
    checks++;
    if (nbusy !== W + 1) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, want %0d", nbusy, W + 1);
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL basic_done_pulses: got %0d, want 1", ndone);
    end
    checks++;
    if ({co, s} !== 9'h100 || s_end !== 8'h00) begin
      errors++;
      $display("FAIL basic_sum: got cout=%b sum=%h held=%h, want cout=1 sum=00", co, s, s_end);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] av [2] = '{8'h5A, 8'd200};
    logic [W-1:0] bv [2] = '{8'hA5, 8'd100};
    logic         cv [2] = '{1'b1, 1'b0};
    logic [8:0]   ev [2] = '{9'h100, 9'h12C};
    logic [W-1:0] s, s_end;
    logic co;
    int lat, nbusy, ndone;
    for (int i = 0; i < 2; i++) begin
      do_op(av[i], bv[i], cv[i], s, co, s_end, lat, nbusy, ndone);
      checks++;
      if ({co, s} !== ev[i] || ndone !== 1) begin
        errors++;
        $display("FAIL vector%0d: got cout=%b sum=%h dones=%0d, want cout=%b sum=%h dones=1",
                 i, co, s, ndone, ev[i][8], ev[i][7:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s, s_end;
    logic c, co;
    logic [8:0] exp;
    int lat, nbusy, ndone;
    for (int i = 0; i < 16; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      exp = 9'(a) + 9'(b) + 9'(c);
      do_op(a, b, c, s, co, s_end, lat, nbusy, ndone);
      checks++;
      if ({co, s} !== exp || s_end !== exp[7:0] || lat !== W) begin
        errors++;
        $display("FAIL random%0d %h+%h+%b: got cout=%b sum=%h held=%h lat=%0d, want %b/%h lat=%0d",
                 i, a, b, c, co, s, s_end, lat, exp[8], exp[7:0], W);
      end
    end
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    logic [W-1:0] s = 'x;
    logic co = 1'bx;
    int nbusy = 0;
    m8.start = 1'b1; m8.a_in = 8'h5A; m8.b_in = 8'h33; m8.cin = 1'b0;
    step();
    for (int k = 0; k < P + 4; k++) begin
      if (m8.busy === 1'b1) nbusy++;
      if (m8.done === 1'b1) begin
        ndone++;
        s  = m8.sum_out;
        co = m8.cout;
      end
      // Re-pulse start during ADD and again during the DONE cycle.
      m8.start = ((k >= 2) && (k <= 4)) || (k == W);
      m8.a_in  = 8'h11;
      m8.b_in  = 8'h22;
      step();
    end
    m8.start = 1'b0;
    checks++;
    if ({co, s} !== 9'h08D || ndone !== 1) begin
      errors++;
      $display("FAIL start_ignored: got cout=%b sum=%h dones=%0d, want cout=0 sum=8d dones=1",
               co, s, ndone);
    end
    checks++;
    if (nbusy !== W + 1) begin
      errors++;
      $display("FAIL start_ignored_busy: got %0d busy cycles, want %0d", nbusy, W + 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s, s_end;
    logic co;
    int lat, nbusy, ndone;
    int stray = 0;
    m8.start = 1'b1; m8.a_in = 8'hC3; m8.b_in = 8'h7E; m8.cin = 1'b1;
    step();
    m8.start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({m8.busy, m8.done, m8.cout, m8.sum_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b cout=%b sum=%h, want all 0",
               m8.busy, m8.done, m8.cout, m8.sum_out);
    end
    for (int k = 0; k < P + 2; k++) begin
      if (m8.done !== 1'b0 || m8.busy !== 1'b0) stray++;
      step();
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d active cycles after abort, want 0", stray);
    end
    do_op(8'h03, 8'h04, 1'b0, s, co, s_end, lat, nbusy, ndone);
    checks++;
    if ({co, s} !== 9'h007 || ndone !== 1) begin
      errors++;
      $display("FAIL reset_mid_next: got cout=%b sum=%h dones=%0d, want cout=0 sum=07 dones=1",
               co, s, ndone);
    end
  endtask

  task automatic test_width1();
    logic [1:0] exp;
    logic [2:0] v;
    int lat;
    logic s, co;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      m1.start = 1'b1; m1.a_in = v[2]; m1.b_in = v[1]; m1.cin = v[0];
      step();
      m1.start = 1'b0;
      lat = -1; s = 1'bx; co = 1'bx;
      for (int k = 0; k < 5; k++) begin
        if (m1.done === 1'b1 && lat < 0) begin
          lat = k;
          s   = m1.sum_out;
          co  = m1.cout;
        end
        step();
      end
      checks++;
      if ({co, s} !== exp || lat !== 1) begin
        errors++;
        $display("FAIL width1 a=%b b=%b cin=%b: got cout=%b sum=%b lat=%0d, want %b/%b lat=1",
                 v[2], v[1], v[0], co, s, lat, exp[1], exp[0]);
      end
    end
  endtask

  // start held high: operations are accepted every P edges, operands taken on those edges only.
  task automatic test_back_to_back();
    logic [W-1:0] av [0:63];
    logic [W-1:0] bv [0:63];
    logic         cv [0:63];
    logic [8:0]   exp;
    int seen = 0;
    int j;
    for (int i = 0; i < 64; i++) begin
      av[i] = W'($urandom);
      bv[i] = W'($urandom);
      cv[i] = 1'($urandom);
    end
    m8.start = 1'b1; m8.a_in = av[0]; m8.b_in = bv[0]; m8.cin = cv[0];
    for (int k = 0; k < 3 * P + 2; k++) begin
      step();
      if (m8.done === 1'b1) begin
        j = seen;
        checks++;
        if (j > 2) begin
          errors++;
          $display("FAIL b2b_extra_done at edge %0d: got done #%0d, want 3 total", k, j + 1);
        end else begin
          exp = 9'(av[j * P]) + 9'(bv[j * P]) + 9'(cv[j * P]);
          if (k !== j * P + W || {m8.cout, m8.sum_out} !== exp) begin
            errors++;
            $display("FAIL b2b_op%0d: got edge %0d cout=%b sum=%h, want edge %0d %b/%h",
                     j, k, m8.cout, m8.sum_out, j * P + W, exp[8], exp[7:0]);
          end
        end
        seen++;
      end
      m8.start = (k + 1 <= 2 * P);
      m8.a_in  = av[k + 1];
      m8.b_in  = bv[k + 1];
      m8.cin   = cv[k + 1];
    end
    m8.start = 1'b0;
    checks++;
    if (seen !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses, want 3", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_width1();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
